// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO and its read-side stream consumer.
package fifo_pkg;

  localparam int DSIZE_DEF     = 8;
  localparam int BURST_LEN_DEF = 4;
  localparam int BCW_DEF       = 2;
  localparam int CNTW_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of the read-side consumer.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
);

  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_last;
  logic             m_ready;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data, m_last
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry {last, data} buffer with occupancy count; entry 0 is always the head.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             push,
  input  logic             push_last,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic             head_last,
  output logic [DSIZE-1:0] head_data,
  output logic [1:0]       level
);

  logic [DSIZE:0] ent0;
  logic [DSIZE:0] ent1;
  logic [DSIZE:0] din;

  assign din = {push_last, push_data};
  assign {head_last, head_data} = ent0;

  // The producer never pushes at level 2 and the consumer never pops at level 0.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      ent0  <= '0;
      ent1  <= '0;
      level <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (level == 2'd0) ent0 <= din;
          else               ent1 <= din;
          level <= level + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          level <= level - 2'd1;
        end
        2'b11: begin
          if (level == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: pops the FIFO into a 2-entry buffer and streams words
// out in fixed-length frames, stopping only on frame boundaries.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int BCW       = BCW_DEF,
  parameter int CNTW      = CNTW_DEF
) (
  input  logic            rclk,
  input  logic            rrst,
  fifo_rd_stream_if.master bus,
  input  logic            en,
  output logic [CNTW-1:0] word_cnt,
  output logic [1:0]      buf_level,
  output logic            busy
);

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [BCW-1:0]   beat_cnt;
  logic [BCW-1:0]   beat_cnt_next;
  logic             beat_wrap;
  logic             xfer;
  logic             buf_last;
  logic [DSIZE-1:0] buf_data;

  // Pop depends only on state, buffer level and the registered empty flag.
  assign bus.rinc  = (state == RUN || state == FINISH) && !bus.rempty && (buf_level != 2'd2);
  assign beat_wrap = (beat_cnt == LAST_BEAT);
  assign xfer      = bus.m_valid && bus.m_ready;

  assign bus.m_valid = (buf_level != 2'd0);
  assign bus.m_data  = buf_data;
  assign bus.m_last  = buf_last;
  assign busy        = (state != IDLE);

  always_comb begin
    beat_cnt_next = beat_cnt;
    if (bus.rinc) beat_cnt_next = beat_wrap ? '0 : beat_cnt + 1'b1;
  end

  skid_buf2 #(
    .DSIZE (DSIZE)
  ) u_buf (
    .rclk      (rclk),
    .rrst      (rrst),
    .push      (bus.rinc),
    .push_last (beat_wrap),
    .push_data (bus.rdata),
    .pop       (xfer),
    .head_last (buf_last),
    .head_data (buf_data),
    .level     (buf_level)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
      if (xfer) word_cnt <= word_cnt + 1'b1;
    end
  end

  // Leaving RUN/FINISH is allowed only once the current frame is complete.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (en) state_next = RUN;
      RUN:    if (!en) state_next = (beat_cnt_next == '0) ? IDLE : FINISH;
      FINISH: begin
        if (en)                        state_next = RUN;
        else if (beat_cnt_next == '0)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
